// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: PC register, synchronous-read instruction memory with a
// load port, and a credit-gated fetch queue presenting {PC, nextPC, Ins} to decode.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              IM_AW    = 8,
  parameter int              FQ_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic             WE,
  input  logic [IM_AW-1:0] W_Addr,
  input  logic [XLEN-1:0]  W_Ins,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_PC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  nextPC,
  output logic [XLEN-1:0]  Ins
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1) + 1;

  logic [XLEN-1:0]  mem [2**IM_AW];
  logic [XLEN-1:0]  q_pc [FQ_DEPTH];
  logic [XLEN-1:0]  q_ins [FQ_DEPTH];

  logic [XLEN-1:0]  fpc;
  logic [XLEN-1:0]  infl_pc;
  logic [XLEN-1:0]  rd_data;
  logic             infl;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    credit;
  logic             pop;
  logic             push;
  logic             issue;
  logic [IM_AW-1:0] rd_idx;
  logic [XLEN-1:0]  head_pc;
  logic [1:0]       unused_rpc_lo;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_rpc_lo = redirect_PC[1:0];
  assign rd_idx        = fpc[IM_AW+1:2];

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = infl & ~redirect;
  // Occupancy the queue will see once the in-flight read lands, net of this pop.
  assign credit    = count + CW'(infl) - CW'(pop);
  assign issue     = run & ~RST & ~redirect & (credit < CW'(FQ_DEPTH));

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc    <= RESET_PC;
      infl   <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      fpc    <= {redirect_PC[XLEN-1:2], 2'b00};
      infl   <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (issue) begin
        fpc     <= fpc + XLEN'(4);
        infl_pc <= fpc;
      end
      infl <= issue;
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop)  rd_ptr <= inc_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      q_pc[wr_ptr]  <= infl_pc;
      q_ins[wr_ptr] <= rd_data;
    end
  end

  // Non-blocking read and write on the same edge give read-before-write.
  always_ff @(posedge CLK) begin
    if (WE)    mem[W_Addr] <= W_Ins;
    if (issue) rd_data     <= mem[rd_idx];
  end

  assign head_pc = q_pc[rd_ptr];
  assign PC      = out_valid ? head_pc : '0;
  assign nextPC  = out_valid ? head_pc + XLEN'(4) : '0;
  assign Ins     = out_valid ? q_ins[rd_ptr] : '0;

endmodule
